// File: rtl/fp_sqrt_pkg.sv
// Shared constants and enumerations for the single-precision square-root datapath.
package fp_sqrt_pkg;

  localparam int          EXP_W    = 8;
  localparam int          MAN_W    = 23;
  localparam int          BIAS     = 127;
  localparam logic [31:0] NAN_VAL  = 32'hFFFFFFFF;
  localparam logic [31:0] PINF_VAL = 32'h7F800000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    OUT
  } state_e;

  typedef enum logic [2:0] {
    CL_NORMAL,
    CL_DENORM,
    CL_ZERO,
    CL_PINF,
    CL_INVALID
  } fp_class_e;

endpackage

// File: rtl/fp_sqrt_classify.sv
// Combinational operand classifier: splits an IEEE-754 word into class, significand and
// unbiased exponent (denormals use the minimum normal exponent, hidden bit 0).
module fp_sqrt_classify
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = fp_sqrt_pkg::EXP_W,
  parameter int MAN_W = fp_sqrt_pkg::MAN_W,
  parameter int BIAS  = fp_sqrt_pkg::BIAS
) (
  input  logic [EXP_W+MAN_W:0]   data,
  output fp_class_e              cls,
  output logic [MAN_W:0]         m,
  output logic signed [EXP_W+1:0] e
);

  localparam int E_W = EXP_W + 2;

  logic             sign;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac;

  assign {sign, exp_f, frac} = data;

  always_comb begin
    cls = CL_NORMAL;
    m   = {1'b1, frac};
    e   = $signed({2'b00, exp_f}) - E_W'(BIAS);
    // Priority order matters: NaN first, then any negative non-zero (covers -inf).
    if (exp_f == '1 && frac != '0) begin
      cls = CL_INVALID;
    end else if (sign && (exp_f != '0 || frac != '0)) begin
      cls = CL_INVALID;
    end else if (exp_f == '1) begin
      cls = CL_PINF;
    end else if (exp_f == '0 && frac == '0) begin
      cls = CL_ZERO;
    end else if (exp_f == '0) begin
      cls = CL_DENORM;
      m   = {1'b0, frac};
      e   = E_W'(1) - E_W'(BIAS);
    end
  end

endmodule

// File: rtl/fp_sqrt_input_stage.sv
// Square-root front end: captures one operand per handshake, resolves special operands,
// normalises denormals and produces the parity-adjusted radicand and halved exponent.
module fp_sqrt_input_stage
  import fp_sqrt_pkg::*;
#(
  parameter int                       EXP_W   = fp_sqrt_pkg::EXP_W,
  parameter int                       MAN_W   = fp_sqrt_pkg::MAN_W,
  parameter int                       BIAS    = fp_sqrt_pkg::BIAS,
  parameter logic [EXP_W+MAN_W:0]     NAN_VAL = fp_sqrt_pkg::NAN_VAL
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXP_W+MAN_W:0]   data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [MAN_W+1:0]       mant_o,
  output logic [EXP_W-1:0]       exp_o,
  output logic                   special_o,
  output logic [EXP_W+MAN_W:0]   special_val_o
);

  localparam int E_W = EXP_W + 2;

  state_e                 state;
  logic [MAN_W:0]         m_q;
  logic signed [E_W-1:0]  e_q;

  fp_class_e              cls;
  logic [MAN_W:0]         cls_m;
  logic signed [E_W-1:0]  cls_e;

  logic [MAN_W:0]         src_m;
  logic signed [E_W-1:0]  src_e;
  logic signed [E_W-1:0]  e_adj;
  logic [MAN_W+1:0]       fin_mant;
  logic [EXP_W-1:0]       fin_exp;

  fp_sqrt_classify #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .BIAS (BIAS)
  ) u_classify (
    .data(data_i),
    .cls (cls),
    .m   (cls_m),
    .e   (cls_e)
  );

  // One finaliser serves both the direct (IDLE) path and the post-shift (NORM) path.
  always_comb begin
    src_m = cls_m;
    src_e = cls_e;
    if (state == NORM) begin
      src_m = m_q << 1;
      src_e = e_q - E_W'(1);
    end
    if (src_e[0]) begin
      fin_mant = {src_m, 1'b0};
      e_adj    = src_e - E_W'(1);
    end else begin
      fin_mant = {1'b0, src_m};
      e_adj    = src_e;
    end
    fin_exp = EXP_W'(e_adj >>> 1) + EXP_W'(BIAS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      in_ready_o    <= 1'b1;
      out_valid_o   <= 1'b0;
      mant_o        <= '0;
      exp_o         <= '0;
      special_o     <= 1'b0;
      special_val_o <= '0;
      m_q           <= '0;
      e_q           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            in_ready_o    <= 1'b0;
            mant_o        <= '0;
            exp_o         <= '0;
            special_o     <= 1'b1;
            special_val_o <= '0;
            out_valid_o   <= 1'b1;
            state         <= OUT;
            case (cls)
              CL_INVALID: special_val_o <= NAN_VAL;
              CL_PINF:    special_val_o <= {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              CL_ZERO:    special_val_o <= data_i;
              CL_NORMAL: begin
                special_o <= 1'b0;
                mant_o    <= fin_mant;
                exp_o     <= fin_exp;
              end
              default: begin
                special_o   <= 1'b0;
                out_valid_o <= 1'b0;
                m_q         <= cls_m;
                e_q         <= cls_e;
                state       <= NORM;
              end
            endcase
          end
        end
        NORM: begin
          m_q <= src_m;
          e_q <= src_e;
          if (src_m[MAN_W]) begin
            mant_o      <= fin_mant;
            exp_o       <= fin_exp;
            out_valid_o <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o   <= 1'b0;
            in_ready_o    <= 1'b1;
            mant_o        <= '0;
            exp_o         <= '0;
            special_o     <= 1'b0;
            special_val_o <= '0;
            state         <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_input_stage.sv
// Directed bench for fp_sqrt_input_stage: table of operands with hand-computed results
// plus stall and mid-normalisation reset sequences.
module tb_fp_sqrt_input_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [24:0] mant_o;
  logic [7:0]  exp_o;
  logic        special_o;
  logic [31:0] special_val_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fp_sqrt_input_stage dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .data_i       (data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .mant_o       (mant_o),
    .exp_o        (exp_o),
    .special_o    (special_o),
    .special_val_o(special_val_o)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
    logic [24:0] mant;
    logic [7:0]  exp;
    logic        special;
    logic [31:0] sval;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Presents one operand, measures capture-to-valid latency, checks outputs, then drains.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk_i);
    data_i     = v.data;
    in_valid_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      in_valid_i = 1'b0;
    end while (!out_valid_o && lat < 40);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " out_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, " mant"}, 32'(mant_o), 32'(v.mant));
    check({tag, " exp"}, 32'(exp_o), 32'(v.exp));
    check({tag, " special"}, 32'(special_o), 32'(v.special));
    check({tag, " special_val"}, special_val_o, v.sval);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check({tag, " drained"}, {31'd0, out_valid_o}, 32'd0);
    check({tag, " ready_again"}, {31'd0, in_ready_o}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{32'h40800000, 1,  25'h0800000, 8'h80, 1'b0, 32'h00000000};
    vecs[1]  = '{32'h41000000, 1,  25'h1000000, 8'h80, 1'b0, 32'h00000000};
    vecs[2]  = '{32'hC0800000, 1,  25'h0000000, 8'h00, 1'b1, 32'hFFFFFFFF};
    vecs[3]  = '{32'h80000000, 1,  25'h0000000, 8'h00, 1'b1, 32'h80000000};
    vecs[4]  = '{32'h7F800000, 1,  25'h0000000, 8'h00, 1'b1, 32'h7F800000};
    vecs[5]  = '{32'h00000000, 1,  25'h0000000, 8'h00, 1'b1, 32'h00000000};
    vecs[6]  = '{32'h7FC00000, 1,  25'h0000000, 8'h00, 1'b1, 32'hFFFFFFFF};
    vecs[7]  = '{32'hFF800000, 1,  25'h0000000, 8'h00, 1'b1, 32'hFFFFFFFF};
    vecs[8]  = '{32'h3F800000, 1,  25'h0800000, 8'h7F, 1'b0, 32'h00000000};
    vecs[9]  = '{32'h00000001, 24, 25'h1000000, 8'h34, 1'b0, 32'h00000000};
    vecs[10] = '{32'h00400000, 2,  25'h1000000, 8'h3F, 1'b0, 32'h00000000};
    vecs[11] = '{32'h7F7FFFFF, 1,  25'h1FFFFFE, 8'hBE, 1'b0, 32'h00000000};
    vecs[12] = '{32'h00800000, 1,  25'h0800000, 8'h40, 1'b0, 32'h00000000};
    vecs[13] = '{32'h00000010, 20, 25'h1000000, 8'h36, 1'b0, 32'h00000000};
    vecs[14] = '{32'h40400000, 1,  25'h1800000, 8'h7F, 1'b0, 32'h00000000};
    vecs[15] = '{32'h80000001, 1,  25'h0000000, 8'h00, 1'b1, 32'hFFFFFFFF};

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    data_i      = '0;
    #12;
    check("reset in_ready", {31'd0, in_ready_o}, 32'd1);
    check("reset out_valid", {31'd0, out_valid_o}, 32'd0);
    check("reset mant", 32'(mant_o), 32'd0);
    check("reset exp", 32'(exp_o), 32'd0);
    check("reset special", {31'd0, special_o}, 32'd0);
    check("reset special_val", special_val_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d_%h", i, vecs[i].data));
    end

    // Denormal keeps the stage busy while it normalises.
    @(negedge clk_i);
    data_i     = 32'h00000001;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk_i);
      check("norm busy", {30'd0, in_ready_o, out_valid_o}, 32'd0);
    end
    @(negedge clk_i);
    check("norm done", {30'd0, in_ready_o, out_valid_o}, 32'd1);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;

    // Stall in OUT with a competing operand on the input.
    @(negedge clk_i);
    data_i     = 32'h40800000;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    data_i = 32'h41000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall valid", {30'd0, out_valid_o, in_ready_o}, 32'd2);
      check("stall mant", 32'(mant_o), 32'h0800000);
      check("stall exp", 32'(exp_o), 32'h80);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("release idle", {30'd0, out_valid_o, in_ready_o}, 32'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("next captured", {30'd0, out_valid_o, in_ready_o}, 32'd2);
    check("next mant", 32'(mant_o), 32'h1000000);
    check("next exp", 32'(exp_o), 32'h80);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;

    // Asynchronous reset during normalisation.
    @(negedge clk_i);
    data_i     = 32'h00000010;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("pre-abort busy", {30'd0, in_ready_o, out_valid_o}, 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort in_ready", {31'd0, in_ready_o}, 32'd1);
    check("abort out_valid", {31'd0, out_valid_o}, 32'd0);
    check("abort fields", {special_o, exp_o, mant_o[22:0]}, 32'd0);
    check("abort mant_hi", 32'(mant_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_vec(vecs[0], "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
